// File: rtl/osc_sequencer.sv
// Step sequencer driving the shared oscillator: plays a programmable pattern of
// (freq, sel, rest) steps at a tempo counted in synchronized sample_clk ticks.
module osc_sequencer #(
    parameter int FREQ_BITS  = 12,
    parameter int STEP_BITS  = 4,
    parameter int TEMPO_BITS = 16
) (
    input  logic                  main_clk,
    input  logic                  reset,
    input  logic                  sample_clk,
    input  logic                  wr_en,
    input  logic [STEP_BITS-1:0]  wr_addr,
    input  logic [FREQ_BITS-1:0]  wr_freq,
    input  logic [1:0]            wr_sel,
    input  logic                  wr_rest,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [STEP_BITS-1:0]  len,
    input  logic [TEMPO_BITS-1:0] tempo,
    output logic [FREQ_BITS-1:0]  freq,
    output logic [1:0]            sel,
    output logic                  gate,
    output logic                  osc_reset,
    output logic [STEP_BITS-1:0]  step,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH   = 2 ** STEP_BITS;
    localparam int ENTRY_W = FREQ_BITS + 3;
    localparam logic [TEMPO_BITS-1:0] TEMPO_ONE = 1;
    localparam logic [STEP_BITS-1:0]  STEP_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PLAY
    } state_t;

    state_t state, state_nxt;

    logic                  sclk_p0, sclk_p1, sclk_p2;
    logic                  tick;
    logic [ENTRY_W-1:0]    pattern [DEPTH];
    logic [TEMPO_BITS-1:0] cnt, cnt_nxt, tempo_last;
    logic                  load, finish, abort;
    logic [STEP_BITS-1:0]  load_addr;
    logic [FREQ_BITS-1:0]  ld_freq;
    logic [1:0]            ld_sel;
    logic                  ld_rest;

    // Stage boundary: two-flop synchronizer (p0, p1) plus edge-detect history (p2)
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
        end else begin
            sclk_p0 <= sample_clk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
        end
    end

    assign tick = sclk_p1 & ~sclk_p2;

    always_ff @(posedge main_clk) begin
        if (wr_en) begin
            pattern[wr_addr] <= {wr_freq, wr_sel, wr_rest};
        end
    end

    assign {ld_freq, ld_sel, ld_rest} = pattern[load_addr];
    assign tempo_last = (tempo == '0) ? '0 : tempo - TEMPO_ONE;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        load_addr = step;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (tick) begin
                    state_nxt = PLAY;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                    load_addr = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (tick) begin
                    if (cnt == tempo_last) begin
                        cnt_nxt = '0;
                        if (step != len) begin
                            load      = 1'b1;
                            load_addr = step + STEP_ONE;
                        end else if (loop_en) begin
                            load      = 1'b1;
                            load_addr = '0;
                        end else begin
                            state_nxt = IDLE;
                            finish    = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + TEMPO_ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage boundary: step load registers feeding the oscillator
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            freq      <= '0;
            sel       <= '0;
            gate      <= 1'b0;
            osc_reset <= 1'b1;
            step      <= '0;
            done      <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            done <= finish;
            if (load) begin
                freq      <= ld_freq;
                sel       <= ld_sel;
                gate      <= ~ld_rest;
                step      <= load_addr;
                osc_reset <= 1'b0;
            end else if (finish || abort) begin
                // freq/sel deliberately hold so the oscillator sees no glitch
                gate      <= 1'b0;
                osc_reset <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_osc_sequencer.sv
// Randomized self-checking bench for osc_sequencer against a sample-period-level
// behavioural model of the pattern player.
module tb_osc_sequencer;

    localparam int FB    = 12;
    localparam int SB    = 4;
    localparam int TW    = 16;
    localparam int DEPTH = 2 ** SB;

    logic          main_clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_clk = 1'b0;
    logic          wr_en = 1'b0;
    logic [SB-1:0] wr_addr = '0;
    logic [FB-1:0] wr_freq = '0;
    logic [1:0]    wr_sel = '0;
    logic          wr_rest = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [SB-1:0] len = '0;
    logic [TW-1:0] tempo = '0;
    logic [FB-1:0] freq;
    logic [1:0]    sel;
    logic          gate;
    logic          osc_reset;
    logic [SB-1:0] step;
    logic          busy;
    logic          done;

    osc_sequencer #(.FREQ_BITS(FB), .STEP_BITS(SB), .TEMPO_BITS(TW)) dut (
        .main_clk  (main_clk),
        .reset     (reset),
        .sample_clk(sample_clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_freq   (wr_freq),
        .wr_sel    (wr_sel),
        .wr_rest   (wr_rest),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .len       (len),
        .tempo     (tempo),
        .freq      (freq),
        .sel       (sel),
        .gate      (gate),
        .osc_reset (osc_reset),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    always #10 main_clk = ~main_clk;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Reference pattern memory and player state, advanced once per sample period
    logic [FB-1:0] pat_f [DEPTH];
    logic [1:0]    pat_s [DEPTH];
    bit            pat_r [DEPTH];
    bit            m_arm, m_play, m_gate, m_oscr;
    int            m_step, m_age, m_done;
    logic [FB-1:0] m_freq;
    logic [1:0]    m_sel;

    always @(negedge main_clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_arm = 0; m_play = 0; m_step = 0; m_age = 0;
        m_freq = '0; m_sel = '0; m_gate = 0; m_oscr = 1;
    endtask

    task automatic model_load(input int a);
        m_step = a; m_age = 0;
        m_freq = pat_f[a]; m_sel = pat_s[a]; m_gate = !pat_r[a]; m_oscr = 0;
    endtask

    task automatic model_period(input bit stopped);
        int t;
        t = (tempo == 0) ? 1 : int'(tempo);
        if (stopped && (m_arm || m_play)) begin
            m_arm = 0; m_play = 0; m_gate = 0; m_oscr = 1;
        end else if (m_arm) begin
            m_arm = 0; m_play = 1;
            model_load(0);
        end else if (m_play) begin
            m_age++;
            if (m_age >= t) begin
                if (m_step != int'(len)) model_load((m_step + 1) % DEPTH);
                else if (loop_en) model_load(0);
                else begin
                    m_play = 0; m_gate = 0; m_oscr = 1; m_done++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".freq"}, 32'(freq), 32'(m_freq));
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".gate"}, 32'(gate), 32'(m_gate));
        chk({tag, ".osc_reset"}, 32'(osc_reset), 32'(m_oscr));
        chk({tag, ".step"}, 32'(step), m_step);
        chk({tag, ".busy"}, 32'(busy), 32'(m_arm | m_play));
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    task automatic write_step(input int a, input logic [FB-1:0] f, input logic [1:0] s, input bit r);
        wr_en = 1; wr_addr = SB'(a); wr_freq = f; wr_sel = s; wr_rest = r;
        pat_f[a] = f; pat_s[a] = s; pat_r[a] = r;
        @(negedge main_clk);
        wr_en = 0;
    endtask

    task automatic start_pulse();
        start = 1;
        @(negedge main_clk);
        start = 0;
        if (!m_arm && !m_play) m_arm = 1;
    endtask

    // One sample period of 8 main clocks; with_stop raises stop+start on the tick cycle
    task automatic period(input bit with_stop, input string tag);
        sample_clk = 1;
        @(negedge main_clk);
        @(negedge main_clk);
        if (with_stop) begin stop = 1; start = 1; end
        @(negedge main_clk);
        stop = 0; start = 0;
        @(negedge main_clk);
        sample_clk = 0;
        repeat (4) @(negedge main_clk);
        model_period(with_stop);
        check_outputs(tag);
    endtask

    initial begin
        logic [FB-1:0] old_f;
        m_done = 0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pat_f[i] = '0; pat_s[i] = '0; pat_r[i] = 0;
        end

        #5 reset = 0;
        repeat (50) @(negedge main_clk);
        check_outputs("reset");
        reset = 1;
        @(negedge main_clk);
        for (int i = 0; i < 10; i++) period(0, "idle");

        // Basic play, one shot
        for (int i = 0; i < 4; i++) write_step(i, FB'(100 * (i + 1)), 2'(i), 0);
        len = 3; tempo = 4; loop_en = 0;
        start_pulse();
        chk("arm.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) period(0, "basic");
        start_pulse();
        for (int i = 0; i < 14; i++) period(0, "basic");
        chk("basic.done_count", done_seen, m_done);
        chk("basic.done_once", done_seen, 1);

        // Loop with a rest step
        write_step(2, FB'(300), 2'd2, 1);
        loop_en = 1;
        start_pulse();
        for (int i = 0; i < 49; i++) period(0, "loop");
        period(1, "loop_stop");
        chk("loop.done_count", done_seen, 1);

        // Tempo 0 behaves as 1
        tempo = 0; len = 1;
        start_pulse();
        for (int i = 0; i < 6; i++) period(0, "tempo0");
        period(1, "tempo0_stop");

        // Stop and start together on an advance tick
        tempo = 2; len = 3; loop_en = 0;
        start_pulse();
        period(0, "stop_pri");
        period(0, "stop_pri");
        period(1, "stop_pri_hit");
        chk("stop_pri.step", 32'(step), 32'd0);
        for (int i = 0; i < 3; i++) period(0, "stop_pri_idle");
        chk("stop_pri.done_count", done_seen, m_done);

        // Live write to the playing step, then asynchronous reset mid-step
        tempo = 4; loop_en = 1;
        start_pulse();
        period(0, "live");
        period(0, "live");
        old_f = freq;
        write_step(0, FB'(3000), 2'd1, 0);
        period(0, "live");
        chk("live.hold", 32'(freq), 32'(old_f));
        for (int i = 0; i < 15; i++) period(0, "live");
        chk("live.reload", 32'(freq), 32'd3000);
        #3 reset = 0;
        #2;
        model_reset();
        check_outputs("async_reset");
        @(negedge main_clk);
        reset = 1;
        @(negedge main_clk);
        for (int i = 0; i < 3; i++) period(0, "post_reset");

        // Randomized patterns, tempos, lengths, stops and live len changes
        for (int r = 0; r < 6; r++) begin
            int n;
            for (int i = 0; i < DEPTH; i++)
                write_step(i, FB'($urandom), 2'($urandom), bit'($urandom_range(0, 3) == 0));
            len = SB'($urandom_range(0, 5));
            tempo = TW'($urandom_range(0, 3));
            loop_en = 1'($urandom);
            start_pulse();
            n = $urandom_range(10, 30);
            for (int i = 0; i < n; i++) begin
                if (r[0] && i == n / 2) len = SB'($urandom_range(0, 15));
                period($urandom_range(0, 24) == 0, "rand");
            end
            period(1, "rand_end");
        end
        chk("final.done_count", done_seen, m_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
